lmul_seq: RTL and testbench
===========================

Name: lmul_seq

Overview:
- Iterative 32x32->64 long-multiply unit for UMULL/SMULL.
- Sits directly downstream of the execute-stage control. It consumes the operands of a long-multiply instruction and produces the 64-bit product for the ALUWB2 write-back path (lmulFlag-driven dual register write).
- Radix-2 shift-add engine with a start/done handshake. It holds its result until the next accepted start.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- is_signed  input  1  1 = SMULL (two's-complement operands), 0 = UMULL; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; result valid from this cycle on.
- result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH].
- result_lo  output  WIDTH  product bits [WIDTH-1:0].
- flag_n  output  1  product bit 2*WIDTH-1.
- flag_z  output  1  1 when the full 2*WIDTH product is zero.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-high on `reset`.
- Reset values: state=IDLE, busy=0, done=0, result_hi=0, result_lo=0, flag_n=0, flag_z=0, iteration counter=0.
- States:
  - IDLE: if start=1, latch the operands and go to RUN with the counter at 0; otherwise stay.
  - RUN: perform one iteration per cycle. If the counter equals WIDTH-1, go to DONE; otherwise increment the counter.
  - DONE: done=1 for exactly this cycle. Update result_hi, result_lo, flag_n and flag_z in this same cycle. Unconditionally return to IDLE.
- Operand latch:
  - If is_signed=1, store |a| and |b|, and store neg = a[WIDTH-1] XOR b[WIDTH-1].
  - If is_signed=0, store the raw operands with neg=0.
  - |0x80000000| is handled as unsigned 0x80000000, with no overflow.
- Iteration:
  - 2*WIDTH accumulator; the multiplicand is shifted left each cycle and the multiplier shifted right.
  - Add the shifted multiplicand when the multiplier LSB is 1.
- Final product:
  - If neg=1, the result is the two's-complement negation of the accumulator over 2*WIDTH bits; otherwise the accumulator.
  - Negation is applied combinationally at the DONE register load.
- Latency:
  - start sampled in cycle T.
  - RUN occupies cycles T+1 .. T+WIDTH.
  - done is high in cycle T+WIDTH+1.
  - The earliest next start is accepted in cycle T+WIDTH+2.
  - For WIDTH=32, done arrives 33 cycles after start.
- Handshake:
  - start while busy=1 (RUN or DONE) is ignored, with no queuing.
  - Operand changes after acceptance have no effect.
- Result hold: outputs hold their last values through IDLE and through the next RUN. They are replaced only in the next DONE cycle.
- Reset mid-operation: reset in any state forces IDLE and all reset values in the next cycle; the partial product is discarded.
- Reset and start in the same cycle: reset wins and start is ignored.
- Boundary cases:
  - Either operand 0 gives product 0, flag_z=1, flag_n=0. This includes signed negative x 0: neg=1 but the negated 0 is 0, so flag_n=0.
  - Maximum unsigned operands must not lose the carry out of the accumulator; the accumulator is exactly 2*WIDTH bits and the top partial sum fits.

Test Plan:
1. Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 -> done after 33 cycles, result_hi=0xFFFFFFFE, result_lo=0x00000001, flag_n=1, flag_z=0.
2. Signed mixed sign: a=0xFFFFFFFD (-3), b=5, is_signed=1 -> result_hi=0xFFFFFFFF, result_lo=0xFFFFFFF1, flag_n=1. Same operands with is_signed=0 -> result_hi=0x00000004, result_lo=0xFFFFFFF1.
3. Signed corner: a=b=0x80000000, is_signed=1 -> result_hi=0x40000000, result_lo=0x00000000, flag_n=0, flag_z=0.
4. Zero and sign: a=0xFFFFFFFF (-1), b=0, is_signed=1 -> result 0, flag_z=1, flag_n=0. Done pulse width is exactly 1 cycle.
5. Handshake:
   - Start (a=7, b=6), then hold start=1 with a=9, b=9 through RUN and DONE -> first result 42 at T+33.
   - The held start is accepted at T+34 -> result 81 at T+67.
   - busy is high in T+1..T+33 and low at T+34 before re-rising.
   - result stays 42 from T+34 until the second done.
6. Reset mid-operation: start (a=3, b=3), assert reset at RUN cycle 10 -> next cycle busy=0, done=0, results 0. A fresh start (a=2, b=2) then yields result_lo=4 after 33 cycles with no stale contribution.

Source files
------------

// File: rtl/lmul_seq_if.sv
// rtl/lmul_seq_if.sv - start/done handshake and result bundle for the long-multiply unit
interface lmul_seq_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;
   logic             flag_n;
   logic             flag_z;

   modport master (
      output start, is_signed, a, b,
      input  busy, done, result_hi, result_lo, flag_n, flag_z
   );

   modport slave (
      input  start, is_signed, a, b,
      output busy, done, result_hi, result_lo, flag_n, flag_z
   );
endinterface

// File: rtl/lmul_seq.sv
// rtl/lmul_seq.sv - iterative radix-2 shift-add 32x32->64 multiplier for UMULL/SMULL
module lmul_seq #(
   parameter int WIDTH = 32
) (
   input  logic      clk,
   input  logic      reset,
   lmul_seq_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;

   logic [2*WIDTH-1:0] r_mcand;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_mplier;
   logic               r_neg;
   logic [CW-1:0]      r_cnt;

   logic [WIDTH-1:0]   r_res_hi;
   logic [WIDTH-1:0]   r_res_lo;
   logic               r_flag_n;
   logic               r_flag_z;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_acc_next;
   logic [2*WIDTH-1:0] w_product;
   logic               w_last;

   // Magnitudes are taken in WIDTH bits: -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
   assign w_a_neg    = bus.is_signed & bus.a[WIDTH-1];
   assign w_b_neg    = bus.is_signed & bus.b[WIDTH-1];
   assign w_a_mag    = w_a_neg ? -bus.a : bus.a;
   assign w_b_mag    = w_b_neg ? -bus.b : bus.b;

   assign w_addend   = r_mplier[0] ? r_mcand : '0;
   assign w_acc_next = r_acc + w_addend;
   assign w_product  = r_neg ? -w_acc_next : w_acc_next;
   assign w_last     = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (bus.start) w_next_state = S_RUN;
         S_RUN:  if (w_last)    w_next_state = S_DONE;
         S_DONE: w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Results load on the final iteration edge so they are already visible while done is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcand  <= '0;
         r_acc    <= '0;
         r_mplier <= '0;
         r_neg    <= 1'b0;
         r_cnt    <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                  r_mplier <= w_b_mag;
                  r_neg    <= w_a_neg ^ w_b_neg;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_RUN: begin
               r_acc    <= w_acc_next;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               if (w_last) begin
                  r_res_hi <= w_product[2*WIDTH-1:WIDTH];
                  r_res_lo <= w_product[WIDTH-1:0];
                  r_flag_n <= w_product[2*WIDTH-1];
                  r_flag_z <= (w_product == '0);
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.busy      = (r_state == S_RUN) || (r_state == S_DONE);
   assign bus.done      = (r_state == S_DONE);
   assign bus.result_hi = r_res_hi;
   assign bus.result_lo = r_res_lo;
   assign bus.flag_n    = r_flag_n;
   assign bus.flag_z    = r_flag_z;
endmodule

// File: tb/tb_lmul_seq.sv
// tb/tb_lmul_seq.sv - scoreboard bench for lmul_seq against a plain-arithmetic product model
module tb_lmul_seq;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   lmul_seq_if #(.WIDTH(W)) bus ();
   lmul_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [63:0] p;
      int          due;
      string       tag;
   } exp_t;

   exp_t        scb[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          in_reset = 1'b1;
   bit          prev_done = 1'b0;
   logic [63:0] held_p = '0;
   logic [1:0]  held_nz = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit s);
      longint sa;
      longint sx;
      if (s) begin
         sa = longint'($signed(a));
         sx = longint'($signed(b));
         return sa * sx;
      end
      return {32'b0, a} * {32'b0, b};
   endfunction

   // Monitor: every done pops the scoreboard; between dones the outputs must hold.
   always @(negedge clk) begin
      if (!in_reset) begin
         if (bus.done) begin
            chk("done_pulse_width", {63'b0, prev_done}, 64'd0);
            if (scb.size() == 0) begin
               chk("unexpected_done", 64'd1, 64'd0);
            end else begin
               mon_e = scb.pop_front();
               chk({mon_e.tag, "_cycle"}, cyc, mon_e.due);
               chk({mon_e.tag, "_hi"}, {32'b0, bus.result_hi}, {32'b0, mon_e.p[63:32]});
               chk({mon_e.tag, "_lo"}, {32'b0, bus.result_lo}, {32'b0, mon_e.p[31:0]});
               chk({mon_e.tag, "_n"}, {63'b0, bus.flag_n}, {63'b0, mon_e.p[63]});
               chk({mon_e.tag, "_z"}, {63'b0, bus.flag_z}, {63'b0, (mon_e.p == 64'd0)});
               held_p  = mon_e.p;
               held_nz = {mon_e.p[63], (mon_e.p == 64'd0)};
            end
         end else begin
            chk("hold_result", {bus.result_hi, bus.result_lo}, held_p);
            chk("hold_flags", {62'b0, bus.flag_n, bus.flag_z}, {62'b0, held_nz});
            if (scb.size() > 0 && cyc > scb[0].due) begin
               chk({scb[0].tag, "_timeout"}, cyc, scb[0].due);
               void'(scb.pop_front());
            end
         end
      end
      prev_done = bus.done;
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) chk("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (scb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", scb.size(), 64'd0);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s, input string tag);
      wait_idle();
      bus.a         = a;
      bus.b         = b;
      bus.is_signed = s;
      bus.start     = 1'b1;
      scb.push_back('{ref_mul(a, b, s), cyc + 33, tag});
      @(negedge clk);
      bus.start     = 1'b0;
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.is_signed = 1'($urandom_range(0, 1));
   endtask

   task automatic check_zero_state(input string tag);
      chk({tag, "_busy"}, {63'b0, bus.busy}, 64'd0);
      chk({tag, "_done"}, {63'b0, bus.done}, 64'd0);
      chk({tag, "_result"}, {bus.result_hi, bus.result_lo}, 64'd0);
      chk({tag, "_flags"}, {62'b0, bus.flag_n, bus.flag_z}, 64'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int t0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      reset         = 1'b1;
      repeat (3) @(negedge clk);
      check_zero_state("reset");
      reset    = 1'b0;
      held_p   = '0;
      held_nz  = '0;
      in_reset = 1'b0;
      @(negedge clk);

      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "umax");
      issue(32'hFFFF_FFFD, 32'd5, 1'b1, "smix");
      issue(32'hFFFF_FFFD, 32'd5, 1'b0, "umix");
      issue(32'h8000_0000, 32'h8000_0000, 1'b1, "smin");
      issue(32'hFFFF_FFFF, 32'd0, 1'b1, "negzero");
      drain();

      // Held start: second request is taken the first IDLE cycle after done.
      wait_idle();
      bus.a = 32'd7; bus.b = 32'd6; bus.is_signed = 1'b0; bus.start = 1'b1;
      t0 = cyc;
      scb.push_back('{64'd42, t0 + 33, "hs_first"});
      @(negedge clk);
      bus.a = 32'd9; bus.b = 32'd9;
      scb.push_back('{64'd81, t0 + 67, "hs_second"});
      for (int k = 1; k <= 33; k++) begin
         chk("hs_busy_high", {63'b0, bus.busy}, 64'd1);
         @(negedge clk);
      end
      chk("hs_busy_gap", {63'b0, bus.busy}, 64'd0);
      chk("hs_hold_42", {bus.result_hi, bus.result_lo}, 64'd42);
      @(negedge clk);
      bus.start = 1'b0;
      chk("hs_busy_rerise", {63'b0, bus.busy}, 64'd1);
      drain();

      // Reset during RUN cycle 10 discards the partial product.
      issue(32'd3, 32'd3, 1'b0, "mid_rst");
      repeat (9) @(negedge clk);
      reset    = 1'b1;
      in_reset = 1'b1;
      scb.delete();
      @(negedge clk);
      check_zero_state("mid_reset");
      held_p   = '0;
      held_nz  = '0;
      reset    = 1'b0;
      in_reset = 1'b0;
      issue(32'd2, 32'd2, 1'b0, "fresh");
      drain();

      for (int i = 0; i < 24; i++) begin
         issue(pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), "rand");
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.a     = $urandom;
            bus.b     = $urandom;
            @(negedge clk);
            bus.start = 1'b0;
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
